// File: rtl/seq_divider_16by8.sv
// -----------------------------------------------------------------------------
// seq_divider_16by8
//
// Sequential restoring radix-2 divider: a 2W-bit unsigned dividend divided by
// a W-bit unsigned divisor, one quotient bit per clock. It is used to recover
// multiplier operands from products (product / A -> B, remainder 0).
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high. The source holds its data and valid until that edge;
// the sink's ready never depends combinationally on valid.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   in_valid     operand pair valid
//   in_ready     block can accept operands (high only in IDLE)
//   dividend     2W-bit unsigned numerator
//   divisor      W-bit unsigned denominator
//   out_valid    result valid (high only in DONE)
//   out_ready    consumer accepts result
//   quotient     W-bit quotient ({W{1}} on any error)
//   remainder    W-bit remainder
//   div_by_zero  divisor was zero
//   overflow     true quotient does not fit in W bits
//
// Latency from the accepting edge N: out_valid rises after edge N+W+1 for a
// normal divide and after edge N+1 for an error case.
// -----------------------------------------------------------------------------
module seq_divider_16by8 #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Working registers. The partial remainder is stored in W bits: after every
  // restoring step it is strictly below the divisor, so its MSB would always
  // be zero. The W+1-bit shifted value only exists combinationally.
  logic [W-1:0]  r;
  logic [W-1:0]  shreg;       // remaining low dividend bits, MSB first
  logic [W-1:0]  q;           // quotient bits collected so far
  logic [W-1:0]  dvs;         // captured divisor
  logic [CW-1:0] cnt;
  logic          last;        // next CALC cycle publishes the result
  logic          dbz_p;
  logic          ovf_p;

  logic          accept;
  logic [W:0]    r_shift;
  logic [W-1:0]  r_diff;
  logic          q_bit;

  assign accept  = in_valid && (state == IDLE);

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // When q_bit is 1 the true difference is below 2^W, so the W-bit modular
  // subtraction is exact.
  assign r_shift = {r, shreg[W-1]};
  assign q_bit   = (r_shift >= {1'b0, dvs});
  assign r_diff  = r_shift[W-1:0] - dvs;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Error cases also pass through CALC for exactly one
  // cycle (with last preset) so they share the result-publish path.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = CALC;
      CALC:    if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r           <= '0;
      shreg       <= '0;
      q           <= '0;
      dvs         <= '0;
      cnt         <= '0;
      last        <= 1'b0;
      dbz_p       <= 1'b0;
      ovf_p       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dvs   <= divisor;
            shreg <= dividend[W-1:0];
            cnt   <= CW'(W - 1);
            if (divisor == '0) begin
              last  <= 1'b1;
              dbz_p <= 1'b1;
              ovf_p <= 1'b0;
              q     <= '1;
              r     <= dividend[W-1:0];
            end else if (dividend[2*W-1:W] >= divisor) begin
              last  <= 1'b1;
              dbz_p <= 1'b0;
              ovf_p <= 1'b1;
              q     <= '1;
              r     <= '0;
            end else begin
              last  <= 1'b0;
              dbz_p <= 1'b0;
              ovf_p <= 1'b0;
              q     <= '0;
              r     <= dividend[2*W-1:W];
            end
          end
        end
        CALC: begin
          if (last) begin
            quotient    <= q;
            remainder   <= r;
            div_by_zero <= dbz_p;
            overflow    <= ovf_p;
            last        <= 1'b0;
          end else begin
            r     <= q_bit ? r_diff : r_shift[W-1:0];
            shreg <= {shreg[W-2:0], 1'b0};
            q     <= {q[W-2:0], q_bit};
            cnt   <= cnt - 1'b1;
            if (cnt == '0) begin
              last <= 1'b1;
            end
          end
        end
        default: ;  // DONE: result registers hold until the next publish
      endcase
    end
  end

endmodule
